// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants for a 4-clk-per-pixel line scan.
// All boundaries are inclusive and sized to the counter they are compared against.
package vga_timing_pkg;

   localparam int H_W     = 12;
   localparam int V_W     = 10;
   localparam int PIX_W   = 10;
   localparam int FRAME_W = 8;

   localparam logic [H_W-1:0] H_VIS_END    = 12'd2559;
   localparam logic [H_W-1:0] H_SYNC_START = 12'd2624;
   localparam logic [H_W-1:0] H_SYNC_END   = 12'd3007;
   localparam logic [H_W-1:0] H_MAX        = 12'd3199;

   localparam logic [V_W-1:0] V_VIS_END    = 10'd479;
   localparam logic [V_W-1:0] V_SYNC_START = 10'd490;
   localparam logic [V_W-1:0] V_SYNC_END   = 10'd491;
   localparam logic [V_W-1:0] V_MAX        = 10'd524;

endpackage

// File: rtl/vga_line_counter.sv
// Line index 0..V_MAX; steps once per line_end and wraps to 0 after V_MAX.
// Asynchronous active-high reset clears it to line 0.
module vga_line_counter
   import vga_timing_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           line_end,
   output logic [V_W-1:0] V_counter
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         V_counter <= '0;
      end else if (line_end) begin
         if (V_counter == V_MAX) begin
            V_counter <= '0;
         end else begin
            V_counter <= V_counter + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/visible-region decoder driven by an external line-scan count; outputs lag H_counter by 1 clk.
// Define VGA_FRAME_CNT_EN to add the frame_cnt output (frames completed, mod 256).
module vga_sync_gen
   import vga_timing_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [H_W-1:0]     H_counter,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [PIX_W-1:0]   pixel_x,
   output logic [PIX_W-1:0]   pixel_y,
   output logic [V_W-1:0]     V_counter
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [FRAME_W-1:0] frame_cnt
`endif
);

   logic line_end;
   logic h_vis;
   logic v_vis;
   logic h_sync_on;
   logic v_sync_on;
   logic vis;

   // Out-of-range counts (> H_MAX) fall through every window below, i.e. back porch.
   assign line_end  = (H_counter == H_MAX);
   assign h_vis     = (H_counter <= H_VIS_END);
   assign v_vis     = (V_counter <= V_VIS_END);
   assign h_sync_on = (H_counter >= H_SYNC_START) && (H_counter <= H_SYNC_END);
   assign v_sync_on = (V_counter >= V_SYNC_START) && (V_counter <= V_SYNC_END);
   assign vis       = h_vis && v_vis;

   vga_line_counter u_line_counter (
      .clk       (clk),
      .reset     (reset),
      .line_end  (line_end),
      .V_counter (V_counter)
   );

   // V_counter here is the pre-update value, so a line's last cycle still decodes as that line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         video_on <= 1'b0;
         pixel_x  <= '0;
         pixel_y  <= '0;
      end else begin
         hsync    <= ~h_sync_on;
         vsync    <= ~v_sync_on;
         video_on <= vis;
         pixel_x  <= vis ? H_counter[H_W-1:2] : '0;
         pixel_y  <= vis ? V_counter : '0;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (line_end && (V_counter == V_MAX)) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: hand-written vector table plus model-fed scoreboard sweeps.
module tb_vga_sync_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] H_counter;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [9:0]  V_counter;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0]  frame_cnt;
`endif

   vga_sync_gen dut (
      .clk       (clk),
      .reset     (reset),
      .H_counter (H_counter),
      .hsync     (hsync),
      .vsync     (vsync),
      .video_on  (video_on),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .V_counter (V_counter)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       vo;
      logic [9:0] px;
      logic [9:0] py;
      logic [9:0] vc;
   } exp_t;

   typedef struct {
      logic [11:0] h;
      exp_t        e;
   } vec_t;

   exp_t       sb_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [9:0] m_v   = '0;
   exp_t       last;
   vec_t       tbl[13];

   function automatic exp_t mk(input logic hs, input logic vs, input logic vo,
                               input int px, input int py, input int vc);
      exp_t e;
      e.hs = hs; e.vs = vs; e.vo = vo;
      e.px = 10'(px); e.py = 10'(py); e.vc = 10'(vc);
      return e;
   endfunction

   function automatic vec_t mkv(input int h, input exp_t e);
      vec_t v;
      v.h = 12'(h);
      v.e = e;
      return v;
   endfunction

   // Reference timing model written directly from the line/frame windows.
   function automatic exp_t predict(input logic [11:0] h, input logic [9:0] v);
      exp_t e;
      logic vis;
      vis  = (h < 12'd2560) && (v < 10'd480);
      e.hs = !((h >= 12'd2624) && (h <= 12'd3007));
      e.vs = !((v == 10'd490) || (v == 10'd491));
      e.vo = vis;
      e.px = vis ? 10'(h / 4) : 10'd0;
      e.py = vis ? v : 10'd0;
      if (h == 12'd3199) e.vc = (v == 10'd524) ? 10'd0 : v + 10'd1;
      else               e.vc = v;
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.hs = hsync; a.vs = vsync; a.vo = video_on;
      a.px = pixel_x; a.py = pixel_y; a.vc = V_counter;
      return a;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got hs=%b vs=%b vo=%b px=%0d py=%0d vc=%0d, expected hs=%b vs=%b vo=%b px=%0d py=%0d vc=%0d",
                  name, act.hs, act.vs, act.vo, act.px, act.py, act.vc,
                  exp.hs, exp.vs, exp.vo, exp.px, exp.py, exp.vc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive h, queue the expectation (hand value or model), compare the registered result.
   task automatic step(input logic [11:0] h, input bit use_hand, input exp_t hand, input string name);
      exp_t e;
      @(negedge clk);
      H_counter = h;
      e = use_hand ? hand : predict(h, m_v);
      sb_q.push_back(e);
      m_v = e.vc;
      @(posedge clk);
      #1;
      last = actual();
      check(name, last, sb_q.pop_front());
   endtask

   task automatic sweep_line(output int hs_low, output int vs_low, output int first_low_h);
      hs_low = 0; vs_low = 0; first_low_h = -1;
      for (int h = 0; h <= 3199; h++) begin
         step(12'(h), 1'b0, '0, "sweep");
         if (!last.hs) begin
            hs_low++;
            if (first_low_h < 0) first_low_h = h;
         end
         if (!last.vs) vs_low++;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_low, vs_low, first_h, vs_total;

      tbl[0]  = mkv(0,    mk(1, 1, 1, 0,   0, 0));
      tbl[1]  = mkv(3,    mk(1, 1, 1, 0,   0, 0));
      tbl[2]  = mkv(4,    mk(1, 1, 1, 1,   0, 0));
      tbl[3]  = mkv(1000, mk(1, 1, 1, 250, 0, 0));
      tbl[4]  = mkv(2559, mk(1, 1, 1, 639, 0, 0));
      tbl[5]  = mkv(2560, mk(1, 1, 0, 0,   0, 0));
      tbl[6]  = mkv(2623, mk(1, 1, 0, 0,   0, 0));
      tbl[7]  = mkv(2624, mk(0, 1, 0, 0,   0, 0));
      tbl[8]  = mkv(3007, mk(0, 1, 0, 0,   0, 0));
      tbl[9]  = mkv(3008, mk(1, 1, 0, 0,   0, 0));
      tbl[10] = mkv(3200, mk(1, 1, 0, 0,   0, 0));
      tbl[11] = mkv(4095, mk(1, 1, 0, 0,   0, 0));
      tbl[12] = mkv(3199, mk(1, 1, 0, 0,   0, 1));

      reset = 1'b1;
      H_counter = 12'd1000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", actual(), mk(1, 1, 0, 0, 0, 0));
`ifdef VGA_FRAME_CNT_EN
      check_int("reset_frame_cnt", int'(frame_cnt), 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      m_v = '0;

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].h, 1'b1, tbl[i].e, $sformatf("table[%0d] h=%0d", i, tbl[i].h));
      end

      sweep_line(hs_low, vs_low, first_h);
      check_int("hsync_low_cycles", hs_low, 384);
      check_int("hsync_first_low_h", first_h, 2624);

      while (m_v != 10'd479) step(12'd3199, 1'b0, '0, "advance_479");
      step(12'd2559, 1'b1, mk(1, 1, 1, 639, 479, 479), "last_visible_pixel");
      step(12'd2560, 1'b1, mk(1, 1, 0, 0, 0, 479), "first_hfp_line479");

      while (m_v != 10'd490) step(12'd3199, 1'b0, '0, "advance_490");
      vs_total = 0;
      for (int l = 0; l < 3; l++) begin
         sweep_line(hs_low, vs_low, first_h);
         vs_total += vs_low;
      end
      check_int("vsync_low_cycles", vs_total, 6400);

      while (m_v != 10'd524) step(12'd3199, 1'b0, '0, "advance_524");
      step(12'd3199, 1'b1, mk(1, 1, 0, 0, 0, 0), "frame_wrap");
`ifdef VGA_FRAME_CNT_EN
      check_int("frame_cnt_after_frame", int'(frame_cnt), 1);
`endif

      for (int i = 0; i < 10; i++) begin
         step(12'd3500, 1'b1, mk(1, 1, 0, 0, 0, 0), "out_of_range_hold");
      end

      while (m_v != 10'd300) step(12'd3199, 1'b0, '0, "advance_300");
      step(12'd1000, 1'b1, mk(1, 1, 1, 250, 300, 300), "mid_frame_pixel");

      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", actual(), mk(1, 1, 0, 0, 0, 0));
`ifdef VGA_FRAME_CNT_EN
      check_int("async_reset_frame_cnt", int'(frame_cnt), 0);
`endif
      m_v = '0;
      @(negedge clk);
      reset = 1'b0;
      step(12'd100,  1'b1, mk(1, 1, 1, 25, 0, 0), "first_edge_after_reset");
      step(12'd3199, 1'b0, '0, "count_from_0_a");
      step(12'd3199, 1'b0, '0, "count_from_0_b");
      check_int("line_after_reset", int'(V_counter), 2);
      check_int("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 clk  input  1  system clock, 100 MHz, all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 H_counter  input  12  upstream line-scan cycle count; legal range 0..3199, one step per clk.
REQ-004 hsync  output  1  horizontal sync, active-low.
REQ-005 vsync  output  1  vertical sync, active-low.
REQ-006 video_on  output  1  high while the current position is in the 640x480 visible region.
REQ-007 pixel_x  output  10  visible column 0..639, 0 outside the visible region.
REQ-008 pixel_y  output  10  visible row 0..479, 0 outside the visible region.
REQ-009 V_counter  output  10  current line index 0..524.
REQ-010 frame_cnt  output  8  frames completed, mod 256; present only with VGA_FRAME_CNT_EN.

Function
REQ-011 Horizontal timing, 4 clk per pixel, SHALL be decoded from the sampled H_counter: visible 0..2559, front porch 2560..2623, sync 2624..3007, back porch 3008..3199.
REQ-012 Vertical timing SHALL be: visible lines 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-013 V_counter SHALL increment on the edge at which H_counter==3199 is sampled, and SHALL wrap from 524 to 0 on that edge.
REQ-014 V_counter SHALL hold on every other edge.
REQ-015 hsync, vsync, video_on, pixel_x and pixel_y SHALL be registered, with exactly 1 clk latency from the H_counter value they decode.
REQ-016 These outputs SHALL use the V_counter value held before that edge's update.
REQ-017 hsync SHALL be 0 iff the sampled H_counter is in 2624..3007.
REQ-018 vsync SHALL be 0 iff V_counter is in 490..491.
REQ-019 video_on SHALL be 1 iff the sampled H_counter < 2560 and V_counter < 480.
REQ-020 pixel_x SHALL be H_counter[11:2] when video_on is asserted, else 0.
REQ-021 pixel_y SHALL be V_counter when video_on is asserted, else 0.
REQ-022 An H_counter value > 3199 SHALL be treated as back porch: hsync=1, video_on=0, no V_counter change.
REQ-023 Comparisons SHALL be unsigned, with constants sized to the operand width and no truncation.

Reset
REQ-024 While reset is high: hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, V_counter=0, frame_cnt=0.
REQ-025 Reset SHALL take effect asynchronously, including mid-line and mid-frame; there is no resynchronisation of a partial frame.
REQ-026 After reset deasserts, the first edge SHALL decode the then-present H_counter against V_counter=0.

Configuration
REQ-027 With VGA_FRAME_CNT_EN defined: frame_cnt SHALL increment on the edge where V_counter wraps 524->0, and SHALL wrap 255->0.
REQ-028 Without VGA_FRAME_CNT_EN: the frame_cnt port and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 Package vga_timing_pkg SHALL hold all H/V boundary constants (H_VIS_END, H_SYNC_START, H_SYNC_END, H_MAX, V_VIS_END, V_SYNC_START, V_SYNC_END, V_MAX) and the width localparams.
REQ-030 The line counter SHALL be sub-module vga_line_counter (inputs clk, reset, line_end; output V_counter), instantiated once; decode logic stays in vga_sync_gen.

Verification
REQ-031 Drive H_counter 0..3199 repeatedly after reset -> hsync low exactly 384 clk per line, first low 1 clk after H_counter=2624 is sampled.
REQ-032 Run one full frame (1,680,000 clk) -> V_counter steps 0..524 then 0; vsync low for exactly 2 lines (6400 clk); frame_cnt=1 when enabled.
REQ-033 Sample H_counter=2559 then 2560 on line 479 -> video_on=1, pixel_x=639, pixel_y=479, then video_on=0, pixel_x=0, pixel_y=0.
REQ-034 Sample H_counter=3199 with V_counter=524 -> next edge V_counter=0; outputs for that cycle still reflect line 524 (vsync=1, video_on=0).
REQ-035 Assert reset with V_counter=300 and H_counter=1000 -> all outputs at reset values immediately, without waiting for a clk edge; after release, V_counter counts from 0.
REQ-036 Hold H_counter=3500 for 10 clk -> V_counter unchanged, hsync=1, video_on=0.
